// File: rtl/bbc_csr_pkg.sv
// Shared types and constants for the CSR bus initiator.
package bbc_csr_pkg;

    localparam int unsigned CSR_SEL_W              = 16;
    localparam int unsigned CSR_ADDR_W             = 16;
    localparam int unsigned CSR_DATA_W             = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    localparam logic [CSR_DATA_W-1:0] CSR_DATA_ZERO    = 32'h0000_0000;
    localparam logic [CSR_DATA_W-1:0] CSR_TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_RESPOND   = 2'd3
    } csr_state_e;

    // True while a bus transaction is outstanding and the abort timer may run.
    function automatic logic is_busy(input csr_state_e s);
        return (s == ST_REQUEST) || (s == ST_READ_WAIT);
    endfunction

endpackage

// File: rtl/bbc_csr_initiator_if.sv
// Host command, CSR bus and completion signals of the initiator.
interface bbc_csr_initiator_if;
    import bbc_csr_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_read_not_write;
    logic [CSR_SEL_W-1:0]  cmd_select;
    logic [CSR_ADDR_W-1:0] cmd_address;
    logic [CSR_DATA_W-1:0] cmd_data;

    logic                  csr_request__valid;
    logic                  csr_request__read_not_write;
    logic [CSR_SEL_W-1:0]  csr_request__select;
    logic [CSR_ADDR_W-1:0] csr_request__address;
    logic [CSR_DATA_W-1:0] csr_request__data;

    logic                  csr_response__ack;
    logic                  csr_response__read_data_valid;
    logic [CSR_DATA_W-1:0] csr_response__read_data;

    logic                  rsp_valid;
    logic [CSR_DATA_W-1:0] rsp_data;
    logic                  rsp_timeout;

    modport master (
        input  cmd_valid, cmd_read_not_write, cmd_select, cmd_address, cmd_data,
        output cmd_ready,
        output csr_request__valid, csr_request__read_not_write,
               csr_request__select, csr_request__address, csr_request__data,
        input  csr_response__ack, csr_response__read_data_valid, csr_response__read_data,
        output rsp_valid, rsp_data, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_read_not_write, cmd_select, cmd_address, cmd_data,
        input  cmd_ready,
        input  csr_request__valid, csr_request__read_not_write,
               csr_request__select, csr_request__address, csr_request__data,
        output csr_response__ack, csr_response__read_data_valid, csr_response__read_data,
        input  rsp_valid, rsp_data, rsp_timeout
    );

endinterface

// File: rtl/bbc_csr_timeout_timer.sv
// Abort timer for outstanding CSR transactions; exists only when
// BBC_CSR_INITIATOR_TIMEOUT_EN is defined.
`ifdef BBC_CSR_INITIATOR_TIMEOUT_EN
module bbc_csr_timeout_timer
    import bbc_csr_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TIMER_W = 16;
    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(LIMIT - 32'd1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear dominates, otherwise count while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {TIMER_W{1'b0}};
        end else if (enable) begin
            count_d = count_q + {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {TIMER_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the LIMIT-th enabled cycle, so the abort lands after LIMIT cycles.
    assign expired = enable && (count_q == LAST_COUNT);

endmodule
`endif

// File: rtl/bbc_csr_initiator.sv
// Single-outstanding CSR bus initiator with registered outputs.
// Optional abort timer enabled by BBC_CSR_INITIATOR_TIMEOUT_EN.
module bbc_csr_initiator
    import bbc_csr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bbc_csr_initiator_if.master  csr_if
);

    csr_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  req_valid_q, req_valid_d;
    logic                  req_rnw_q, req_rnw_d;
    logic [CSR_SEL_W-1:0]  req_sel_q, req_sel_d;
    logic [CSR_ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [CSR_DATA_W-1:0] req_data_q, req_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [CSR_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  timer_expired_s;

`ifdef BBC_CSR_INITIATOR_TIMEOUT_EN
    logic timer_clear_s;
    logic timer_enable_s;

    assign timer_enable_s = is_busy(state_q);
    assign timer_clear_s  = !timer_enable_s ||
                            ((state_q == ST_REQUEST) && csr_if.csr_response__ack);

    bbc_csr_timeout_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (timer_expired_s)
    );
`else
    // No timer: never expires (TIMEOUT_CYCLES is never zero).
    assign timer_expired_s = (TIMEOUT_CYCLES == 32'd0);
`endif

    // Next-state and next-output logic; responses from the bus win over expiry.
    always_comb begin
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_rnw_d     = req_rnw_q;
        req_sel_d     = req_sel_q;
        req_addr_d    = req_addr_q;
        req_data_d    = req_data_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (csr_if.cmd_valid && cmd_ready_q) begin
                    state_d     = ST_REQUEST;
                    req_valid_d = 1'b1;
                    req_rnw_d   = csr_if.cmd_read_not_write;
                    req_sel_d   = csr_if.cmd_select;
                    req_addr_d  = csr_if.cmd_address;
                    req_data_d  = csr_if.cmd_read_not_write ? CSR_DATA_ZERO : csr_if.cmd_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (csr_if.csr_response__ack || timer_expired_s) begin
                    req_valid_d = 1'b0;
                    req_rnw_d   = 1'b0;
                    req_sel_d   = {CSR_SEL_W{1'b0}};
                    req_addr_d  = {CSR_ADDR_W{1'b0}};
                    req_data_d  = CSR_DATA_ZERO;
                end else begin
                    req_valid_d = req_valid_q;
                end
                if (csr_if.csr_response__ack) begin
                    if (!req_rnw_q) begin
                        state_d       = ST_RESPOND;
                        rsp_data_d    = CSR_DATA_ZERO;
                        rsp_timeout_d = 1'b0;
                    end else if (csr_if.csr_response__read_data_valid) begin
                        state_d       = ST_RESPOND;
                        rsp_data_d    = csr_if.csr_response__read_data;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d = ST_READ_WAIT;
                    end
                end else if (timer_expired_s) begin
                    state_d       = ST_RESPOND;
                    rsp_data_d    = CSR_TIMEOUT_DATA;
                    rsp_timeout_d = 1'b1;
                end else begin
                    state_d = ST_REQUEST;
                end
            end
            ST_READ_WAIT: begin
                if (csr_if.csr_response__read_data_valid) begin
                    state_d       = ST_RESPOND;
                    rsp_data_d    = csr_if.csr_response__read_data;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired_s) begin
                    state_d       = ST_RESPOND;
                    rsp_data_d    = CSR_TIMEOUT_DATA;
                    rsp_timeout_d = 1'b1;
                end else begin
                    state_d = ST_READ_WAIT;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
                req_rnw_d   = 1'b0;
                req_sel_d   = {CSR_SEL_W{1'b0}};
                req_addr_d  = {CSR_ADDR_W{1'b0}};
                req_data_d  = CSR_DATA_ZERO;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESPOND);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            req_valid_q   <= 1'b0;
            req_rnw_q     <= 1'b0;
            req_sel_q     <= {CSR_SEL_W{1'b0}};
            req_addr_q    <= {CSR_ADDR_W{1'b0}};
            req_data_q    <= CSR_DATA_ZERO;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= CSR_DATA_ZERO;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            req_valid_q   <= req_valid_d;
            req_rnw_q     <= req_rnw_d;
            req_sel_q     <= req_sel_d;
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign csr_if.cmd_ready                   = cmd_ready_q;
    assign csr_if.csr_request__valid          = req_valid_q;
    assign csr_if.csr_request__read_not_write = req_rnw_q;
    assign csr_if.csr_request__select         = req_sel_q;
    assign csr_if.csr_request__address        = req_addr_q;
    assign csr_if.csr_request__data           = req_data_q;
    assign csr_if.rsp_valid                   = rsp_valid_q;
    assign csr_if.rsp_data                    = rsp_data_q;
    assign csr_if.rsp_timeout                 = rsp_timeout_q;

endmodule

// File: tb/tb_bbc_csr_initiator.sv
// Directed bench for bbc_csr_initiator; completions checked against a scoreboard.
module tb_bbc_csr_initiator;
    import bbc_csr_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        timeout;
    } rsp_exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bbc_csr_initiator_if bus_if();

    bbc_csr_initiator #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .csr_if  (bus_if)
    );

    rsp_exp_t sb[$];
    rsp_exp_t mon_e;
    int       n_cmp = 0;
    int       n_err = 0;
    int       rsp_count = 0;
    int       req_count = 0;
    logic     prev_rsp_valid = 1'b0;
    logic     prev_req_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every rsp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (bus_if.csr_request__valid === 1'b1 && prev_req_valid !== 1'b1) req_count++;
        if (bus_if.rsp_valid === 1'b1) begin
            rsp_count++;
            chk("rsp_pulse_width", {31'h0, prev_rsp_valid}, 32'h0);
            chk("rsp_expected", {31'h0, (sb.size() != 0)}, 32'h1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_data", bus_if.rsp_data, mon_e.data);
                chk("rsp_timeout", {31'h0, bus_if.rsp_timeout}, {31'h0, mon_e.timeout});
            end
        end
        prev_rsp_valid = bus_if.rsp_valid;
        prev_req_valid = bus_if.csr_request__valid;
    end

    task automatic wait_ready(input string tag);
        int i = 0;
        while (bus_if.cmd_ready !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_ready"}, {31'h0, bus_if.cmd_ready}, 32'h1);
    endtask

    // Present one command; returns on the first cycle the request is on the bus.
    task automatic issue(input string tag, input logic rnw, input logic [15:0] sel,
                         input logic [15:0] addr, input logic [31:0] data);
        wait_ready(tag);
        bus_if.cmd_valid          = 1'b1;
        bus_if.cmd_read_not_write = rnw;
        bus_if.cmd_select         = sel;
        bus_if.cmd_address        = addr;
        bus_if.cmd_data           = data;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic rnw, input logic [15:0] sel,
                             input logic [15:0] addr, input logic [31:0] data);
        chk({tag, "_req_valid"}, {31'h0, bus_if.csr_request__valid}, 32'h1);
        chk({tag, "_req_rnw"}, {31'h0, bus_if.csr_request__read_not_write}, {31'h0, rnw});
        chk({tag, "_req_sel"}, {16'h0, bus_if.csr_request__select}, {16'h0, sel});
        chk({tag, "_req_addr"}, {16'h0, bus_if.csr_request__address}, {16'h0, addr});
        chk({tag, "_req_data"}, bus_if.csr_request__data, data);
    endtask

    initial begin
        int base;
        int hi;
        int guard;

        bus_if.cmd_valid                     = 1'b0;
        bus_if.cmd_read_not_write            = 1'b0;
        bus_if.cmd_select                    = 16'h0;
        bus_if.cmd_address                   = 16'h0;
        bus_if.cmd_data                      = 32'h0;
        bus_if.csr_response__ack             = 1'b0;
        bus_if.csr_response__read_data_valid = 1'b0;
        bus_if.csr_response__read_data       = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'h0, bus_if.cmd_ready}, 32'h0);
        chk("rst_req_valid", {31'h0, bus_if.csr_request__valid}, 32'h0);
        chk("rst_req_sel", {16'h0, bus_if.csr_request__select}, 32'h0);
        chk("rst_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
        chk("rst_rsp_data", bus_if.rsp_data, 32'h0);
        chk("rst_rsp_timeout", {31'h0, bus_if.rsp_timeout}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'h0, bus_if.cmd_ready}, 32'h1);

        // Write, ack three cycles after valid.
        sb.push_back('{32'h0000_0000, 1'b0});
        issue("wr", 1'b0, 16'h0003, 16'h0010, 32'hDEAD_BEEF);
        check_req("wr_c0", 1'b0, 16'h0003, 16'h0010, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_req("wr_hold", 1'b0, 16'h0003, 16'h0010, 32'hDEAD_BEEF);
        end
        bus_if.csr_response__ack = 1'b1;
        @(negedge clk);
        bus_if.csr_response__ack = 1'b0;
        chk("wr_valid_drop", {31'h0, bus_if.csr_request__valid}, 32'h0);
        chk("wr_fields_zero", {16'h0, bus_if.csr_request__select}, 32'h0);
        chk("wr_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
        @(negedge clk);
        chk("wr_rsp_one_cycle", {31'h0, bus_if.rsp_valid}, 32'h0);
        chk("wr_ready_back", {31'h0, bus_if.cmd_ready}, 32'h1);

        // Read with ack and data together: minimum latency.
        sb.push_back('{32'h1234_5678, 1'b0});
        issue("rd0", 1'b1, 16'h0001, 16'h0020, 32'hCAFE_F00D);
        check_req("rd0", 1'b1, 16'h0001, 16'h0020, 32'h0000_0000);
        bus_if.csr_response__ack             = 1'b1;
        bus_if.csr_response__read_data_valid = 1'b1;
        bus_if.csr_response__read_data       = 32'h1234_5678;
        @(negedge clk);
        bus_if.csr_response__ack             = 1'b0;
        bus_if.csr_response__read_data_valid = 1'b0;
        bus_if.csr_response__read_data       = 32'h0;
        chk("rd0_rsp_n2", {31'h0, bus_if.rsp_valid}, 32'h1);
        @(negedge clk);
        chk("rd0_ready_n3", {31'h0, bus_if.cmd_ready}, 32'h1);

        // Read via READ_WAIT, stray read_data_valid before ack.
        sb.push_back('{32'hA5A5_A5A5, 1'b0});
        issue("rd1", 1'b1, 16'h0002, 16'h0030, 32'h0);
        bus_if.csr_response__read_data_valid = 1'b1;
        bus_if.csr_response__read_data       = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_if.csr_response__read_data_valid = 1'b0;
        check_req("rd1_stray_rdv", 1'b1, 16'h0002, 16'h0030, 32'h0);
        chk("rd1_no_rsp", {31'h0, bus_if.rsp_valid}, 32'h0);
        bus_if.csr_response__ack = 1'b1;
        @(negedge clk);
        bus_if.csr_response__ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rd1_wait_valid_low", {31'h0, bus_if.csr_request__valid}, 32'h0);
            chk("rd1_wait_no_rsp", {31'h0, bus_if.rsp_valid}, 32'h0);
            @(negedge clk);
        end
        chk("rd1_wait_not_ready", {31'h0, bus_if.cmd_ready}, 32'h0);
        bus_if.csr_response__read_data_valid = 1'b1;
        bus_if.csr_response__read_data       = 32'hA5A5_A5A5;
        @(negedge clk);
        bus_if.csr_response__read_data_valid = 1'b0;
        chk("rd1_rsp", {31'h0, bus_if.rsp_valid}, 32'h1);
        @(negedge clk);

        // Stray responses in IDLE.
        bus_if.csr_response__ack             = 1'b1;
        bus_if.csr_response__read_data_valid = 1'b1;
        bus_if.csr_response__read_data       = 32'h1111_1111;
        repeat (2) @(negedge clk);
        bus_if.csr_response__ack             = 1'b0;
        bus_if.csr_response__read_data_valid = 1'b0;
        chk("idle_stray_ready", {31'h0, bus_if.cmd_ready}, 32'h1);
        chk("idle_stray_valid", {31'h0, bus_if.csr_request__valid}, 32'h0);
        chk("idle_stray_rsp", {31'h0, bus_if.rsp_valid}, 32'h0);
        chk("idle_rsp_data_hold", bus_if.rsp_data, 32'hA5A5_A5A5);

        // cmd_valid held with new fields while busy must not be taken.
        base = req_count;
        sb.push_back('{32'h0000_0000, 1'b0});
        issue("held", 1'b0, 16'h0005, 16'h0040, 32'h0102_0304);
        bus_if.cmd_valid   = 1'b1;
        bus_if.cmd_select  = 16'h0006;
        bus_if.cmd_address = 16'h0050;
        bus_if.cmd_data    = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_req("held", 1'b0, 16'h0005, 16'h0040, 32'h0102_0304);
        end
        bus_if.cmd_valid         = 1'b0;
        bus_if.csr_response__ack = 1'b1;
        @(negedge clk);
        bus_if.csr_response__ack = 1'b0;
        chk("held_rsp", {31'h0, bus_if.rsp_valid}, 32'h1);
        repeat (2) @(negedge clk);
        chk("held_single_req", req_count - base, 32'd1);

        // Reset mid-REQUEST.
        base = rsp_count;
        issue("rst_mid", 1'b0, 16'h0007, 16'h0070, 32'h0000_0077);
        chk("rst_mid_valid", {31'h0, bus_if.csr_request__valid}, 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_async_valid", {31'h0, bus_if.csr_request__valid}, 32'h0);
        chk("rst_mid_ready", {31'h0, bus_if.cmd_ready}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_count - base, 32'd0);
        sb.push_back('{32'h55AA_55AA, 1'b0});
        issue("post_rst", 1'b1, 16'h0008, 16'h0080, 32'h0);
        bus_if.csr_response__ack             = 1'b1;
        bus_if.csr_response__read_data_valid = 1'b1;
        bus_if.csr_response__read_data       = 32'h55AA_55AA;
        @(negedge clk);
        bus_if.csr_response__ack             = 1'b0;
        bus_if.csr_response__read_data_valid = 1'b0;
        chk("post_rst_rsp", {31'h0, bus_if.rsp_valid}, 32'h1);
        @(negedge clk);

`ifdef BBC_CSR_INITIATOR_TIMEOUT_EN
        // Timeout abort after 16 cycles of valid.
        sb.push_back('{32'hFFFF_FFFF, 1'b1});
        issue("to", 1'b1, 16'h0009, 16'h0090, 32'h0);
        hi    = 1;
        guard = 0;
        while (bus_if.csr_request__valid === 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus_if.csr_request__valid === 1'b1) hi++;
        end
        chk("to_valid_cycles", hi, 32'd16);
        chk("to_rsp", {31'h0, bus_if.rsp_valid}, 32'h1);
        @(negedge clk);

        // Ack in the expiry cycle completes normally.
        sb.push_back('{32'h0000_0000, 1'b0});
        issue("to_ack", 1'b0, 16'h000A, 16'h00A0, 32'h0A0A_0A0A);
        repeat (15) @(negedge clk);
        chk("to_ack_still_valid", {31'h0, bus_if.csr_request__valid}, 32'h1);
        bus_if.csr_response__ack = 1'b1;
        @(negedge clk);
        bus_if.csr_response__ack = 1'b0;
        chk("to_ack_rsp", {31'h0, bus_if.rsp_valid}, 32'h1);
        @(negedge clk);
`else
        hi    = 0;
        guard = 0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bbc_csr_initiator.md
BBC_CSR_INITIATOR -- requirements
Module: bbc_csr_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, cycles in REQUEST/READ_WAIT before abort (8..65535).
REQ-002 Single clock clk; reset_n asynchronous active-low; all state clocked on rising clk.
REQ-003 clk  in  1  system clock.
REQ-004 reset_n  in  1  async active-low reset.
REQ-005 cmd_valid  in  1  host command present.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_read_not_write  in  1  1=read, 0=write.
REQ-008 cmd_select  in  16  target CSR select.
REQ-009 cmd_address  in  16  CSR address.
REQ-010 cmd_data  in  32  write data.
REQ-011 csr_request__valid, __read_not_write  out  1 each  CSR bus request.
REQ-012 csr_request__select, __address  out  16 each; csr_request__data  out  32.
REQ-013 csr_response__ack, __read_data_valid  in  1 each; csr_response__read_data  in  32.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_data  out  32  read data (0 for writes).
REQ-016 rsp_timeout  out  1  completion was a timeout abort.

Function
REQ-017 States IDLE, REQUEST, READ_WAIT, RESPOND; all outputs registered.
REQ-018 IDLE: cmd_ready=1; on cmd_valid capture all cmd fields, go REQUEST; cmd_ready=0 in every other state.
REQ-019 csr_request__valid SHALL rise the cycle after acceptance and hold, with select/address/read_not_write/data stable, until the cycle after ack is sampled.
REQ-020 csr_request__data SHALL be 0 for reads; all request fields 0 whenever valid=0.
REQ-021 REQUEST, ack=1, write: go RESPOND, rsp_data=0.
REQ-022 REQUEST, ack=1, read, read_data_valid=1 same cycle: capture read_data, go RESPOND.
REQ-023 REQUEST, ack=1, read, read_data_valid=0: go READ_WAIT (valid low).
REQ-024 READ_WAIT: on read_data_valid capture read_data, go RESPOND.
REQ-025 RESPOND: rsp_valid=1 exactly one cycle with rsp_data/rsp_timeout; next state IDLE; rsp_data holds until next RESPOND.
REQ-026 Minimum latency: accept cycle N, valid N+1, ack N+1 -> rsp_valid N+2, cmd_ready N+3.
REQ-027 ack or read_data_valid in IDLE/RESPOND, and read_data_valid in REQUEST without ack, SHALL be ignored.
REQ-028 cmd_valid while not in IDLE SHALL be ignored (not queued).

Reset
REQ-029 reset_n low: state IDLE, cmd_ready=0 while asserted then 1 first cycle after release, all csr_request__* 0, rsp_valid=0, rsp_data=0, rsp_timeout=0, timer 0.
REQ-030 Reset mid-transaction SHALL drop csr_request__valid immediately (async) with no completion pulse.

Configuration
REQ-031 Macro BBC_CSR_INITIATOR_TIMEOUT_EN defined: timer cleared on entering REQUEST and on ack, increments each cycle in REQUEST/READ_WAIT; on reaching TIMEOUT_CYCLES deassert valid, go RESPOND with rsp_timeout=1, rsp_data=32'hFFFF_FFFF.
REQ-032 Ack arriving in the same cycle the timer expires SHALL win (normal completion).
REQ-033 Macro undefined: no timer logic, waits indefinitely, rsp_timeout constant 0, TIMEOUT_CYCLES unused.

Structure
REQ-034 Package bbc_csr_pkg: state enum, CSR select/address/data width constants, TIMEOUT_CYCLES default.
REQ-035 One sub-module bbc_csr_timeout_timer (clear, enable, expired), instantiated only under the macro.

Verification
REQ-036 Write select=0x0003 addr=0x0010 data=0xDEADBEEF, ack 3 cycles after valid -> request fields stable, valid drops after ack, rsp_valid one cycle, rsp_data=0, rsp_timeout=0.
REQ-037 Read, ack and read_data_valid same cycle with 0x12345678 -> rsp_data=0x12345678 next cycle.
REQ-038 Read, ack then read_data_valid 5 cycles later with 0xA5A5A5A5 -> READ_WAIT, valid low, rsp_data=0xA5A5A5A5.
REQ-039 Macro defined, TIMEOUT_CYCLES=16, no ack -> valid high exactly 16 cycles, rsp_timeout=1, rsp_data=0xFFFFFFFF; ack on expiry cycle -> normal completion.
REQ-040 reset_n pulsed low mid-REQUEST -> valid 0 asynchronously, no rsp_valid, next command completes normally.
REQ-041 Stray ack/read_data_valid in IDLE and cmd_valid held during REQUEST -> no state change, no extra command issued.
